rob_commit_unit: RTL and testbench

//   Retirement stage at the pop end of the reorder buffer. Watches the ROB head, and
//   for each completed instruction, in program order:
//   - writes its result into the architectural register file, or
//   - hands a store to the store buffer under a valid/ready handshake,

---
 rtl/rob_commit_unit.sv | 170 +++++++++++++++++
 tb/tb_rob_commit_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_unit.sv
// Retires completed instructions from the ROB head in program order: register results go to the RF, stores go to the store buffer.
// Latency: rob_pop is combinational; RF write is registered, one cycle after the pop edge; a store takes >=2 cycles (capture, then accept).
// Backpressure: a store holds st_valid with stable st_instr/st_data until st_ready; no ROB head is examined meanwhile.
module rob_commit_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rob_empty,
    input  logic             rob_head_ready,
    input  logic [31:0]      rob_head_instr,
    input  logic [31:0]      rob_head_val,
    output logic             rob_pop,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             st_valid,
    output logic [31:0]      st_instr,
    output logic [31:0]      st_data,
    input  logic             st_ready,
    output logic [CNT_W-1:0] commit_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic       ST_IDLE = 1'b0;
    localparam logic       ST_WAIT = 1'b1;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_SW    = 5'b00111;

    localparam logic [4:0] REG_LINK = 5'd31;
    localparam logic [4:0] REG_X    = 5'd30;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             state_q, state_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;
    logic [31:0]      st_instr_q, st_instr_d;
    logic [31:0]      st_data_q, st_data_d;
    logic [CNT_W-1:0] commit_count_q, commit_count_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic [4:0]       head_op;
    logic [4:0]       head_rd;
    logic [4:0]       head_dest;
    logic             head_is_store;
    logic             head_commit;
    logic             head_stall;
    logic             pop_req;
    logic             commit_inc;
    logic             stall_inc;

    // Decode the ROB head: destination register (0 means no architectural write) and store class.
    always_comb begin
        head_op       = rob_head_instr[31:27];
        head_rd       = rob_head_instr[26:22];
        head_is_store = (head_op == OP_SW);
        head_commit   = !rob_empty && rob_head_ready;
        head_stall    = !rob_empty && !rob_head_ready;
        head_dest     = 5'd0;
        case (head_op)
            OP_RTYPE, OP_ADDI, OP_LW: head_dest = head_rd;
            OP_JAL:                   head_dest = REG_LINK;
            OP_SETX:                  head_dest = REG_X;
            default:                  head_dest = 5'd0;
        endcase
    end

    // Retirement FSM: next state, RF write capture, store capture and pop request.
    always_comb begin
        state_d    = state_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        st_instr_d = st_instr_q;
        st_data_d  = st_data_q;
        pop_req    = 1'b0;
        commit_inc = 1'b0;
        stall_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (head_commit) begin
                    if (head_is_store) begin
                        // Store is not popped yet; it stays at the head until the store buffer takes it.
                        st_instr_d = rob_head_instr;
                        st_data_d  = rob_head_val;
                        state_d    = ST_WAIT;
                    end else begin
                        // r0 is hardwired, so a dest of 0 (including no-dest opcodes) suppresses the write.
                        pop_req    = 1'b1;
                        commit_inc = 1'b1;
                        rf_we_d    = (head_dest != 5'd0);
                        rf_waddr_d = head_dest;
                        rf_wdata_d = rob_head_val;
                    end
                end
                if (head_stall) begin
                    stall_inc = 1'b1;
                end
            end
            ST_WAIT: begin
                // Head is not re-sampled here; the captured request is held until accepted.
                if (st_ready) begin
                    pop_req    = 1'b1;
                    commit_inc = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Retire and stall counters; both wrap silently.
    always_comb begin
        commit_count_d = commit_count_q;
        stall_count_d  = stall_count_q;
        if (commit_inc) begin
            commit_count_d = commit_count_q + CNT_ONE;
        end
        if (stall_inc) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end
    end

    // All state registers; async reset returns to IDLE and drops any pending store uncounted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= 5'd0;
            rf_wdata_q     <= 32'd0;
            st_instr_q     <= 32'd0;
            st_data_q      <= 32'd0;
            commit_count_q <= '0;
            stall_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            st_instr_q     <= st_instr_d;
            st_data_q      <= st_data_d;
            commit_count_q <= commit_count_d;
            stall_count_q  <= stall_count_d;
        end
    end

    // Pop is Mealy; it is masked during reset and whenever the ROB reports empty so an empty ROB is never popped.
    always_comb begin
        rob_pop = pop_req && !rob_empty && !reset;
    end

    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign st_valid     = (state_q == ST_WAIT);
    assign st_instr     = st_instr_q;
    assign st_data      = st_data_q;
    assign commit_count = commit_count_q;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: reset, ALU retire, back-to-back, store handshake, stall counting, reset mid-store.
// Inputs change 1 ns after the posedge; combinational outputs are checked 1 ns later, registered ones 1 ns after the edge.
// Every comparison updates pass_cnt/total_cnt and prints a FAIL line on mismatch.
module tb_rob_commit_unit;

    logic        clock;
    logic        reset;
    logic        rob_empty;
    logic        rob_head_ready;
    logic [31:0] rob_head_instr;
    logic [31:0] rob_head_val;
    logic        rob_pop;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        st_valid;
    logic [31:0] st_instr;
    logic [31:0] st_data;
    logic        st_ready;
    logic [31:0] commit_count;
    logic [31:0] stall_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    rob_commit_unit #(.CNT_W(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .rob_empty      (rob_empty),
        .rob_head_ready (rob_head_ready),
        .rob_head_instr (rob_head_instr),
        .rob_head_val   (rob_head_val),
        .rob_pop        (rob_pop),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .st_valid       (st_valid),
        .st_instr       (st_instr),
        .st_data        (st_data),
        .st_ready       (st_ready),
        .commit_count   (commit_count),
        .stall_count    (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd);
        return {op, rd, 22'h12345};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; rob_empty = 1'b1; rob_head_ready = 1'b0;
        rob_head_instr = 32'd0; rob_head_val = 32'd0; st_ready = 1'b0;
        tick(); tick();
        total_cnt++;
        if ({rf_we, rf_waddr, rf_wdata, st_valid, st_instr, st_data} !== 103'd0) $display("FAIL reset_outs got %h want 0", {rf_we, rf_waddr, rf_wdata, st_valid, st_instr, st_data});
        else pass_cnt++;
        total_cnt++;
        if (commit_count !== 32'd0 || stall_count !== 32'd0) $display("FAIL reset_counts got %0d/%0d want 0/0", commit_count, stall_count);
        else pass_cnt++;
        total_cnt++;
        if (rob_pop !== 1'b0) $display("FAIL reset_pop_empty got %b want 0", rob_pop);
        else pass_cnt++;
        // Ready head during reset must still not pop.
        rob_empty = 1'b0; rob_head_ready = 1'b1; rob_head_instr = mk(5'b00101, 5'd7);
        #1;
        total_cnt++;
        if (rob_pop !== 1'b0) $display("FAIL reset_pop_ready got %b want 0", rob_pop);
        else pass_cnt++;
        rob_empty = 1'b1; rob_head_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_addi();
        rob_empty = 1'b0; rob_head_ready = 1'b1;
        rob_head_instr = mk(5'b00101, 5'd5); rob_head_val = 32'h0000002A;
        #1;
        total_cnt++;
        if (rob_pop !== 1'b1) $display("FAIL addi_pop got %b want 1", rob_pop);
        else pass_cnt++;
        tick();
        rob_empty = 1'b1; rob_head_ready = 1'b0;
        total_cnt++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h2A) $display("FAIL addi_rf got we=%b a=%0d d=%h want 1/5/2a", rf_we, rf_waddr, rf_wdata);
        else pass_cnt++;
        total_cnt++;
        if (commit_count !== 32'd1) $display("FAIL addi_count got %0d want 1", commit_count);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (rf_we !== 1'b0) $display("FAIL addi_we_drop got %b want 0", rf_we);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rds  [4];
        logic [31:0] vals [4];
        rds  = '{5'd1, 5'd2, 5'd3, 5'd0};
        vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        rob_empty = 1'b0; rob_head_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rob_head_instr = mk(5'b00000, rds[i]); rob_head_val = vals[i];
            #1;
            total_cnt++;
            if (rob_pop !== 1'b1) $display("FAIL b2b_pop%0d got %b want 1", i, rob_pop);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (i < 3) begin
                if (rf_we !== 1'b1 || rf_waddr !== rds[i] || rf_wdata !== vals[i]) $display("FAIL b2b_rf%0d got we=%b a=%0d d=%h want 1/%0d/%h", i, rf_we, rf_waddr, rf_wdata, rds[i], vals[i]);
                else pass_cnt++;
            end else begin
                if (rf_we !== 1'b0) $display("FAIL b2b_r0_we got %b want 0", rf_we);
                else pass_cnt++;
            end
        end
        rob_empty = 1'b1; rob_head_ready = 1'b0;
        total_cnt++;
        if (commit_count !== 32'd5) $display("FAIL b2b_count got %0d want 5", commit_count);
        else pass_cnt++;
    endtask

    task automatic test_store();
        int pops;
        int vld_cycles;
        pops = 0; vld_cycles = 0;
        rob_empty = 1'b0; rob_head_ready = 1'b1; st_ready = 1'b0;
        rob_head_instr = mk(5'b00111, 5'd9); rob_head_val = 32'hDEADBEEF;
        #1;
        total_cnt++;
        if (rob_pop !== 1'b0) $display("FAIL st_idle_pop got %b want 0", rob_pop);
        else pass_cnt++;
        tick();
        rob_head_val = 32'h0BADF00D;
        for (int c = 0; c < 4; c++) begin
            st_ready = (c == 3);
            #1;
            if (st_valid === 1'b1) vld_cycles++;
            if (rob_pop === 1'b1) pops++;
            total_cnt++;
            if (st_data !== 32'hDEADBEEF || st_instr !== mk(5'b00111, 5'd9) || rf_we !== 1'b0) $display("FAIL st_hold%0d got d=%h i=%h we=%b want deadbeef/%h/0", c, st_data, st_instr, rf_we, mk(5'b00111, 5'd9));
            else pass_cnt++;
            tick();
        end
        rob_empty = 1'b1; rob_head_ready = 1'b0; st_ready = 1'b0;
        total_cnt++;
        if (vld_cycles != 4 || pops != 1) $display("FAIL st_cycles got vld=%0d pops=%0d want 4/1", vld_cycles, pops);
        else pass_cnt++;
        total_cnt++;
        if (st_valid !== 1'b0 || commit_count !== 32'd6 || rf_we !== 1'b0) $display("FAIL st_done got vld=%b cnt=%0d we=%b want 0/6/0", st_valid, commit_count, rf_we);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        int pops;
        pops = 0;
        rob_empty = 1'b0; rob_head_ready = 1'b0;
        rob_head_instr = mk(5'b00011, 5'd4); rob_head_val = 32'h1000;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (rob_pop === 1'b1) pops++;
            tick();
        end
        total_cnt++;
        if (stall_count !== 32'd4 || pops != 0) $display("FAIL stall_count got %0d pops=%0d want 4/0", stall_count, pops);
        else pass_cnt++;
        rob_head_ready = 1'b1;
        #1;
        total_cnt++;
        if (rob_pop !== 1'b1) $display("FAIL stall_release_pop got %b want 1", rob_pop);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 32'h1000) $display("FAIL jal_rf got we=%b a=%0d d=%h want 1/31/1000", rf_we, rf_waddr, rf_wdata);
        else pass_cnt++;
        rob_head_instr = mk(5'b10101, 5'd2); rob_head_val = 32'h55;
        tick();
        total_cnt++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd30 || rf_wdata !== 32'h55) $display("FAIL setx_rf got we=%b a=%0d d=%h want 1/30/55", rf_we, rf_waddr, rf_wdata);
        else pass_cnt++;
        rob_head_instr = mk(5'b11111, 5'd6); rob_head_val = 32'h66;
        #1;
        total_cnt++;
        if (rob_pop !== 1'b1) $display("FAIL other_pop got %b want 1", rob_pop);
        else pass_cnt++;
        tick();
        rob_empty = 1'b1; rob_head_ready = 1'b0;
        total_cnt++;
        if (rf_we !== 1'b0 || commit_count !== 32'd9 || stall_count !== 32'd4) $display("FAIL other_done got we=%b cnt=%0d stall=%0d want 0/9/4", rf_we, commit_count, stall_count);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_store();
        rob_empty = 1'b0; rob_head_ready = 1'b1; st_ready = 1'b0;
        rob_head_instr = mk(5'b00111, 5'd1); rob_head_val = 32'h12345678;
        tick();
        total_cnt++;
        if (st_valid !== 1'b1) $display("FAIL rst_st_enter got %b want 1", st_valid);
        else pass_cnt++;
        #1 reset = 1'b1;
        #1;
        total_cnt++;
        if (st_valid !== 1'b0 || rob_pop !== 1'b0 || commit_count !== 32'd0 || stall_count !== 32'd0) $display("FAIL rst_async got vld=%b pop=%b cnt=%0d stall=%0d want 0/0/0/0", st_valid, rob_pop, commit_count, stall_count);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        #1;
        total_cnt++;
        if (rob_pop !== 1'b0 || st_valid !== 1'b0) $display("FAIL rst_release got pop=%b vld=%b want 0/0", rob_pop, st_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (st_valid !== 1'b1 || st_data !== 32'h12345678) $display("FAIL rst_recapture got vld=%b d=%h want 1/12345678", st_valid, st_data);
        else pass_cnt++;
        st_ready = 1'b1;
        #1;
        total_cnt++;
        if (rob_pop !== 1'b1) $display("FAIL rst_accept_pop got %b want 1", rob_pop);
        else pass_cnt++;
        tick();
        rob_empty = 1'b1; rob_head_ready = 1'b0; st_ready = 1'b0;
        total_cnt++;
        if (st_valid !== 1'b0 || commit_count !== 32'd1) $display("FAIL rst_recommit got vld=%b cnt=%0d want 0/1", st_valid, commit_count);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_store();
        test_stall();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
